// File: rtl/mem_wb_commit.sv
// mem_wb_commit: MEM/WB register stage with delay-slot tracking, exception/interrupt commit and timed flush.
module mem_wb_commit #(
    parameter int                 DATA_W       = 32,
    parameter int                 ADDR_W       = 32,
    parameter int                 RADDR_W      = 5,
    parameter int                 NUM_CH       = 2,
    parameter int                 EXC_W        = 32,
    parameter logic [EXC_W-1:0]   INT_CODE     = 32'h1,
    parameter int                 FLUSH_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_i,
    input  logic                        mem_valid,
    input  logic [ADDR_W-1:0]           mem_pc,
    input  logic                        mem_is_branch,
    input  logic [NUM_CH-1:0]           mem_wen,
    input  logic [NUM_CH*RADDR_W-1:0]   mem_waddr,
    input  logic [NUM_CH*DATA_W-1:0]    mem_wdata,
    input  logic [EXC_W-1:0]            mem_excepttype,
    input  logic [DATA_W-1:0]           cp0_status,
    input  logic [DATA_W-1:0]           cp0_cause,
    output logic                        wb_valid,
    output logic [NUM_CH-1:0]           wb_wen,
    output logic [NUM_CH*RADDR_W-1:0]   wb_waddr,
    output logic [NUM_CH*DATA_W-1:0]    wb_wdata,
    output logic                        exc_en,
    output logic                        exc_is_int,
    output logic [EXC_W-1:0]            exc_type,
    output logic [ADDR_W-1:0]           exc_epc,
    output logic                        exc_bd,
    output logic                        flush_o,
    output logic                        busy
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;

    logic [0:0]                  state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        slot_q, slot_d;
    logic [ADDR_W-1:0]           last_pc_q, last_pc_d;
    logic                        wb_valid_q, wb_valid_d;
    logic [NUM_CH-1:0]           wb_wen_q, wb_wen_d;
    logic [NUM_CH*RADDR_W-1:0]   wb_waddr_q, wb_waddr_d;
    logic [NUM_CH*DATA_W-1:0]    wb_wdata_q, wb_wdata_d;
    logic                        exc_en_q, exc_en_d;
    logic                        exc_is_int_q, exc_is_int_d;
    logic [EXC_W-1:0]            exc_type_q, exc_type_d;
    logic [ADDR_W-1:0]           exc_epc_q, exc_epc_d;
    logic                        exc_bd_q, exc_bd_d;

    logic int_pend, accept, is_exc, is_int, commit, flush_done;

    assign int_pend   = |(cp0_cause[15:8] & cp0_status[15:8]) & cp0_status[0] & ~cp0_status[1];
    assign accept     = mem_valid & ~stall_i & (state_q == IDLE);
    assign is_exc     = |mem_excepttype;
    // Interrupts must not split a branch from its delay slot, so they wait for a plain instruction.
    assign is_int     = int_pend & ~is_exc & ~mem_is_branch & ~slot_q;
    assign commit     = accept & (is_exc | is_int);
    assign flush_done = (state_q == FLUSH) && (cnt_q == '0);

    always_comb begin
        wb_valid_d   = stall_i ? wb_valid_q : accept;
        wb_wen_d     = stall_i ? wb_wen_q : (accept & ~is_exc) ? mem_wen : '0;
        wb_waddr_d   = accept ? mem_waddr : wb_waddr_q;
        wb_wdata_d   = accept ? mem_wdata : wb_wdata_q;
        exc_en_d     = commit;
        exc_is_int_d = commit ? is_int : exc_is_int_q;
        exc_type_d   = commit ? (is_exc ? mem_excepttype : INT_CODE) : exc_type_q;
        exc_epc_d    = commit ? (is_exc ? (slot_q ? last_pc_q : mem_pc) : mem_pc + ADDR_W'(4)) : exc_epc_q;
        exc_bd_d     = commit ? (is_exc & slot_q) : exc_bd_q;
        slot_d       = accept ? (mem_is_branch & ~is_exc) : slot_q;
        last_pc_d    = accept ? mem_pc : last_pc_q;
        state_d      = commit ? FLUSH : flush_done ? IDLE : state_q;
        cnt_d        = commit ? CW'(FLUSH_CYCLES - 1) :
                       (state_q == FLUSH && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            slot_q       <= 1'b0;
            last_pc_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_wen_q     <= '0;
            wb_waddr_q   <= '0;
            wb_wdata_q   <= '0;
            exc_en_q     <= 1'b0;
            exc_is_int_q <= 1'b0;
            exc_type_q   <= '0;
            exc_epc_q    <= '0;
            exc_bd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            last_pc_q    <= last_pc_d;
            wb_valid_q   <= wb_valid_d;
            wb_wen_q     <= wb_wen_d;
            wb_waddr_q   <= wb_waddr_d;
            wb_wdata_q   <= wb_wdata_d;
            exc_en_q     <= exc_en_d;
            exc_is_int_q <= exc_is_int_d;
            exc_type_q   <= exc_type_d;
            exc_epc_q    <= exc_epc_d;
            exc_bd_q     <= exc_bd_d;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_wen     = wb_wen_q;
    assign wb_waddr   = wb_waddr_q;
    assign wb_wdata   = wb_wdata_q;
    assign exc_en     = exc_en_q;
    assign exc_is_int = exc_is_int_q;
    assign exc_type   = exc_type_q;
    assign exc_epc    = exc_epc_q;
    assign exc_bd     = exc_bd_q;
    assign flush_o    = (state_q == FLUSH);
    assign busy       = (state_q == FLUSH);
endmodule

// File: tb/tb_mem_wb_commit.sv
// tb_mem_wb_commit: directed and random stimulus against a behavioural commit/flush model.
module tb_mem_wb_commit;
    localparam int DATA_W = 32, ADDR_W = 32, RADDR_W = 5, NUM_CH = 2, EXC_W = 32, FLUSH_CYCLES = 2;
    localparam logic [EXC_W-1:0] INT_CODE = 32'h1;

    logic clk = 1'b0, rst = 1'b1, stall_i = 1'b0, mem_valid = 1'b0, mem_is_branch = 1'b0;
    logic [ADDR_W-1:0] mem_pc = '0;
    logic [NUM_CH-1:0] mem_wen = '0;
    logic [NUM_CH*RADDR_W-1:0] mem_waddr = '0;
    logic [NUM_CH*DATA_W-1:0] mem_wdata = '0;
    logic [EXC_W-1:0] mem_excepttype = '0;
    logic [DATA_W-1:0] cp0_status = '0, cp0_cause = '0;
    logic wb_valid, exc_en, exc_is_int, exc_bd, flush_o, busy;
    logic [NUM_CH-1:0] wb_wen;
    logic [NUM_CH*RADDR_W-1:0] wb_waddr;
    logic [NUM_CH*DATA_W-1:0] wb_wdata;
    logic [EXC_W-1:0] exc_type;
    logic [ADDR_W-1:0] exc_epc;

    mem_wb_commit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RADDR_W(RADDR_W), .NUM_CH(NUM_CH),
                    .EXC_W(EXC_W), .INT_CODE(INT_CODE), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_is_branch(mem_is_branch), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_excepttype(mem_excepttype), .cp0_status(cp0_status),
        .cp0_cause(cp0_cause), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .exc_en(exc_en), .exc_is_int(exc_is_int), .exc_type(exc_type),
        .exc_epc(exc_epc), .exc_bd(exc_bd), .flush_o(flush_o), .busy(busy));

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    logic run = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // Behavioural model: flush is a count of remaining flush cycles.
    logic m_valid, m_exc_en, m_is_int, m_bd, m_slot;
    logic [NUM_CH-1:0] m_wen;
    logic [NUM_CH*RADDR_W-1:0] m_waddr;
    logic [NUM_CH*DATA_W-1:0] m_wdata;
    logic [EXC_W-1:0] m_type;
    logic [ADDR_W-1:0] m_epc, m_last_pc;
    int m_left;

    always @(posedge clk) begin : model
        logic ex, ip, ir, acc;
        ex  = mem_excepttype != 0;
        ip  = ((cp0_cause[15:8] & cp0_status[15:8]) != 0) && cp0_status[0] && !cp0_status[1];
        acc = mem_valid && !stall_i && m_left == 0;
        ir  = ip && !ex && !mem_is_branch && !m_slot;
        if (rst) begin
            m_valid <= 0; m_wen <= 0; m_waddr <= 0; m_wdata <= 0; m_exc_en <= 0; m_is_int <= 0;
            m_type <= 0; m_epc <= 0; m_bd <= 0; m_slot <= 0; m_last_pc <= 0; m_left <= 0;
        end else begin
            m_exc_en <= acc && (ex || ir);
            if (m_left > 0) m_left <= m_left - 1;
            if (acc) begin
                m_valid <= 1; m_wen <= ex ? '0 : mem_wen; m_waddr <= mem_waddr; m_wdata <= mem_wdata;
                m_slot <= mem_is_branch && !ex; m_last_pc <= mem_pc;
                if (ex || ir) begin
                    m_left <= FLUSH_CYCLES; m_is_int <= ir; m_bd <= ex && m_slot;
                    m_type <= ex ? mem_excepttype : INT_CODE;
                    m_epc <= ex ? (m_slot ? m_last_pc : mem_pc) : mem_pc + 4;
                end
            end else if (!stall_i) begin
                m_valid <= 0; m_wen <= 0;
            end
        end
    end

    always @(negedge clk) if (run) begin
        chk("wb_valid", 64'(wb_valid), 64'(m_valid));
        chk("wb_wen", 64'(wb_wen), 64'(m_wen));
        chk("exc_en", 64'(exc_en), 64'(m_exc_en));
        chk("flush_o", 64'(flush_o), 64'(m_left > 0));
        chk("busy", 64'(busy), 64'(m_left > 0));
        if (m_valid) begin
            chk("wb_waddr", 64'(wb_waddr), 64'(m_waddr));
            chk("wb_wdata", wb_wdata, m_wdata);
        end
        if (m_exc_en) begin
            chk("exc_is_int", 64'(exc_is_int), 64'(m_is_int));
            chk("exc_type", 64'(exc_type), 64'(m_type));
            chk("exc_epc", 64'(exc_epc), 64'(m_epc));
            chk("exc_bd", 64'(exc_bd), 64'(m_bd));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic instr(input logic [ADDR_W-1:0] pc, input logic br, input logic [EXC_W-1:0] et,
                         input logic [DATA_W-1:0] d);
        mem_valid = 1; mem_pc = pc; mem_is_branch = br; mem_excepttype = et;
        mem_wen = 2'b01; mem_waddr = {5'd0, 5'd3}; mem_wdata = {32'h0, d};
    endtask

    task automatic idle();
        mem_valid = 0; mem_is_branch = 0; mem_excepttype = 0; mem_wen = 0;
    endtask

    initial begin
        @(negedge clk); tick(); run = 1; rst = 0;
        chk("rst wb_valid", 64'(wb_valid), 64'd0);
        chk("rst flush_o", 64'(flush_o), 64'd0);
        chk("rst exc_epc", 64'(exc_epc), 64'd0);
        chk("rst wb_wdata", wb_wdata, 64'd0);
        // Back-to-back stream
        for (int i = 1; i <= 4; i++) begin
            instr(32'h10 + 4 * i, 0, 0, 32'(i * 'h11)); tick();
            chk("stream wdata", wb_wdata, 64'(i * 'h11));
            chk("stream exc_en", 64'(exc_en), 64'd0);
        end
        // Exception outside a delay slot, with mem_valid during the flush
        instr(32'h100, 0, 32'h4, 32'h99); tick();
        chk("exc0 en", 64'(exc_en), 64'd1);
        chk("exc0 epc", 64'(exc_epc), 64'h100);
        chk("exc0 bd", 64'(exc_bd), 64'd0);
        chk("exc0 wen", 64'(wb_wen), 64'd0);
        chk("exc0 flush", 64'(flush_o), 64'd1);
        instr(32'h500, 0, 0, 32'h5); tick();
        chk("flush1 flush", 64'(flush_o), 64'd1);
        chk("flush1 valid", 64'(wb_valid), 64'd0);
        tick();
        chk("flush2 flush", 64'(flush_o), 64'd0);
        chk("flush2 valid", 64'(wb_valid), 64'd0);
        tick();
        chk("post flush valid", 64'(wb_valid), 64'd1);
        // Exception in a delay slot
        instr(32'h200, 1, 0, 32'h1); tick();
        instr(32'h204, 0, 32'h8, 32'h2); tick();
        chk("slot exc epc", 64'(exc_epc), 64'h200);
        chk("slot exc bd", 64'(exc_bd), 64'd1);
        idle(); tick(); tick();
        // Interrupt taken, then deferred across a branch and its slot
        cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
        instr(32'h300, 0, 0, 32'h55); tick();
        chk("int en", 64'(exc_en), 64'd1);
        chk("int is_int", 64'(exc_is_int), 64'd1);
        chk("int type", 64'(exc_type), 64'h1);
        chk("int epc", 64'(exc_epc), 64'h304);
        chk("int wen", 64'(wb_wen), 64'd1);
        idle(); tick(); tick();
        instr(32'h400, 1, 0, 32'h1); tick();
        chk("defer br", 64'(exc_en), 64'd0);
        instr(32'h404, 0, 0, 32'h2); tick();
        chk("defer slot", 64'(exc_en), 64'd0);
        instr(32'h408, 0, 0, 32'h3); tick();
        chk("defer third", 64'(exc_en), 64'd1);
        chk("defer epc", 64'(exc_epc), 64'h40c);
        idle(); cp0_cause = 0; tick(); tick();
        // Stall right after an exception accept
        instr(32'h600, 0, 32'h4, 32'h6); tick();
        chk("stall exc en", 64'(exc_en), 64'd1);
        idle(); stall_i = 1; tick();
        chk("stall en0", 64'(exc_en), 64'd0);
        chk("stall valid hold", 64'(wb_valid), 64'd1);
        chk("stall flush", 64'(flush_o), 64'd1);
        tick();
        chk("stall flush end", 64'(flush_o), 64'd0);
        tick(); stall_i = 0; tick();
        // Reset in the middle of a flush
        instr(32'h700, 0, 32'h4, 32'h7); tick();
        idle(); rst = 1; tick();
        chk("rst mid busy", 64'(busy), 64'd0);
        chk("rst mid exc_en", 64'(exc_en), 64'd0);
        chk("rst mid epc", 64'(exc_epc), 64'd0);
        rst = 0; instr(32'h800, 0, 0, 32'h8); tick();
        chk("rst mid accept", 64'(wb_valid), 64'd1);
        // Random phase
        for (int i = 0; i < 1500; i++) begin
            rst = $urandom_range(0, 99) == 0;
            stall_i = $urandom_range(0, 3) == 0;
            mem_valid = $urandom_range(0, 3) != 0;
            mem_pc = $urandom & ~32'h3;
            mem_is_branch = $urandom_range(0, 3) == 0;
            mem_excepttype = $urandom_range(0, 9) == 0 ? 32'($urandom_range(1, 255)) : '0;
            mem_wen = 2'($urandom_range(0, 3));
            mem_waddr = 10'($urandom);
            mem_wdata = {$urandom, $urandom};
            cp0_status = $urandom_range(0, 2) == 0 ? 32'h401 : $urandom;
            cp0_cause = $urandom_range(0, 3) == 0 ? 32'h400 : 32'h0;
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_wb_commit.md
# mem_wb_commit

Parametrised MEM/WB commit stage for the MIPS core. It registers N register-file write channels from MEM into WB with an explicit valid/stall handshake, tracks branch delay slots from a branch flag supplied by MEM, and arbitrates precise exceptions against pending interrupts. After an exception it drives a timed pipeline flush. It sits between the MEM stage and the regfile/HI-LO/CP0 write ports, and feeds CP0 and PC-select with EPC, BD and exception type.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 32, instruction address width
- RADDR_W, 5, write-address width per channel
- NUM_CH, 2, number of write channels (GPR, HI, LO, CP0, ...)
- EXC_W, 32, exception-type vector width
- INT_CODE, 32'h1, exc_type value reported for interrupts
- FLUSH_CYCLES, 2, flush duration after an exception commit (≥1)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- stall_i  in  1  WB stall; holds WB registers
- mem_valid  in  1  MEM holds a real instruction this cycle
- mem_pc  in  ADDR_W  PC of the MEM instruction
- mem_is_branch  in  1  MEM instruction has a delay slot
- mem_wen  in  NUM_CH  per-channel write enable
- mem_waddr  in  NUM_CH*RADDR_W  per-channel address, channel k at [k*RADDR_W +: RADDR_W]
- mem_wdata  in  NUM_CH*DATA_W  per-channel data, channel k at [k*DATA_W +: DATA_W]
- mem_excepttype  in  EXC_W  nonzero means a synchronous exception
- cp0_status, cp0_cause  in  DATA_W  CP0 Status/Cause
- wb_valid  out  1  WB holds a committed instruction
- wb_wen, wb_waddr, wb_wdata  out  same widths as mem_*  registered write channels
- exc_en  out  1  one-cycle exception/interrupt commit pulse
- exc_is_int  out  1  the commit is an interrupt
- exc_type  out  EXC_W  mem_excepttype, or INT_CODE for an interrupt
- exc_epc  out  ADDR_W  EPC to load into CP0
- exc_bd  out  1  the faulting instruction was in a delay slot
- flush_o  out  1  flush IF..MEM
- busy  out  1  state is FLUSH

## Operation
- accept = mem_valid & ~stall_i & (state==IDLE).
- int_pend = |(cp0_cause[15:8] & cp0_status[15:8]) & cp0_status[0] & ~cp0_status[1].
- slot_r is set when an accepted instruction has mem_is_branch=1. It is cleared by any other accept, by an exception commit, and by rst. last_pc_r captures mem_pc on every accept.
- is_slot = slot_r at accept time.
- Exception (mem_excepttype≠0) on accept:
  - wb_wen is forced to 0 (write squashed); wb_valid=1.
  - exc_en=1, exc_is_int=0, exc_type=mem_excepttype.
  - exc_epc = is_slot ? last_pc_r : mem_pc; exc_bd = is_slot.
  - Transition to FLUSH.
- Interrupt on accept (int_pend, no exception, ~mem_is_branch, ~is_slot):
  - The instruction writes normally.
  - exc_en=1, exc_is_int=1, exc_type=INT_CODE, exc_epc=mem_pc+4 (wraps mod 2^ADDR_W), exc_bd=0.
  - Transition to FLUSH.
- An interrupt pending on a branch or a slot instruction is deferred to the next eligible accept.
- An exception wins over an interrupt in the same cycle.
- Normal accept: wb_* loaded from mem_*, wb_valid=1, exc_en=0.
- No accept with ~stall_i: wb_valid=0, wb_wen=0, exc_en=0.
- stall_i=1: all wb_* outputs hold. exc_en is 0 (it never repeats).
- FSM has two states:
  - IDLE → FLUSH on an exception or interrupt commit; counter loads FLUSH_CYCLES-1.
  - FLUSH: flush_o=1, busy=1, mem_valid ignored, wb_valid=0 and wb_wen=0 unless stall_i holds them. The counter decrements every cycle regardless of stall_i.
  - FLUSH → IDLE when the counter reaches 0.

## Timing
- MEM→WB latency is 1 cycle. exc_en, exc_* and the first flush_o cycle appear in the cycle after the accept edge, aligned with wb_valid.
- flush_o stays high for exactly FLUSH_CYCLES consecutive cycles. The first accept is possible in the cycle after flush_o falls.
- exc_type, exc_epc and exc_bd hold their values until the next commit. They are meaningful only while exc_en=1.
- Reset values: wb_valid=0, wb_wen=0, wb_waddr=0, wb_wdata=0, exc_en=0, exc_is_int=0, exc_type=0, exc_epc=0, exc_bd=0, flush_o=0, busy=0, state=IDLE, slot_r=0, counter=0.
- rst mid-FLUSH returns the block to IDLE on the next edge; flush_o drops immediately after that edge.

## Test plan
- Reset, then a back-to-back stream of 4 valid instructions with wen=2'b01, waddr0=3 and data 0x11..0x44 → wb_wdata tracks with 1-cycle lag; exc_en is never set.
- Exception, no delay slot: mem_pc=0x100, excepttype=0x4 → next cycle exc_en=1, exc_epc=0x100, exc_bd=0, wb_wen=0. flush_o is high for 2 cycles. A mem_valid asserted during the flush is ignored.
- Exception in a delay slot: branch at 0x200 accepted, then the slot at 0x204 with excepttype=0x8 → exc_epc=0x200, exc_bd=1.
- Interrupt: status=0x0000_0401, cause=0x0000_0400, pc=0x300 → the write commits, exc_is_int=1, exc_type=INT_CODE, exc_epc=0x304. The same interrupt presented on a branch at 0x400 is deferred: no exc_en on the branch or its slot, then exc_en on the 3rd instruction.
- Stall: stall_i held 3 cycles right after an exception accept → exc_en pulses once; wb_* hold; flush_o still ends after 2 cycles.
- rst asserted in the middle of a flush → the next cycle has all outputs at 0 and busy=0, and an accept succeeds the following cycle.
